// File: rtl/wb_queue.sv
// wb_queue: in-order write-back queue between two producers and a
// two-port register file.
//
// Requests are stored in a circular buffer and drained oldest-first through
// two regfile write ports. Issue-stage source addresses can be checked
// against the pending writes so that dependent instructions can stall.
//
// Handshake: a producer request is taken on a rising clock edge when its
// valid is high and enq_ready is high. enq_ready depends only on the
// registered entry count, never on this cycle's valids. A valid request whose
// byte enables are all zero, or whose address is the zero register, is
// dropped silently. The regfile side has no back-pressure: whatever the wb
// ports present in a cycle is written at the next edge.
module wb_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 6
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enq0_valid,
  input  logic [AW-1:0]            enq0_waddr,
  input  logic [3:0]               enq0_we,
  input  logic [31:0]              enq0_wdata,
  input  logic                     enq1_valid,
  input  logic [AW-1:0]            enq1_waddr,
  input  logic [3:0]               enq1_we,
  input  logic [31:0]              enq1_wdata,
  output logic                     enq_ready,
  output logic [3:0]               wb1_we,
  output logic [AW-1:0]            wb1_waddr,
  output logic [31:0]              wb1_wdata,
  output logic [3:0]               wb2_we,
  output logic [AW-1:0]            wb2_waddr,
  output logic [31:0]              wb2_wdata,
  input  logic [4*AW-1:0]          chk_addr,
  output logic [3:0]               chk_busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Queue control state. Entry validity is derived from head and count only.
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  // Entry storage, not reset.
  logic [AW-1:0] r_waddr [DEPTH];
  logic [3:0]    r_we    [DEPTH];
  logic [31:0]   r_wdata [DEPTH];

  logic          w_acc0;
  logic          w_acc1;
  logic [CW-1:0] w_num_acc;
  logic [PW-1:0] w_slot1;
  logic [PW-1:0] w_head1;
  logic          w_wb1_v;
  logic          w_wb2_v;
  logic [CW-1:0] w_num_drn;
  logic [DEPTH-1:0] w_slot_valid;
  logic [3:0]    w_busy;

  // Room for two requests is judged from the registered count, so the two
  // producers never see a combinational path through each other's valid.
  assign enq_ready = (r_count <= CW'(DEPTH - 2));

  // A request is stored only if it would actually change the register file.
  assign w_acc0 = enq0_valid && enq_ready && (enq0_we != 4'd0) && (enq0_waddr != '0);
  assign w_acc1 = enq1_valid && enq_ready && (enq1_we != 4'd0) && (enq1_waddr != '0);

  assign w_num_acc = CW'(w_acc0) + CW'(w_acc1);

  // enq1 lands directly behind enq0, or at tail when enq0 was not taken.
  assign w_slot1 = r_tail + PW'(w_acc0);

  // Second-oldest slot; wraps naturally because DEPTH is a power of two.
  assign w_head1 = r_head + PW'(1);

  // Port 1 carries the oldest entry whenever the queue is non-empty.
  assign w_wb1_v = (r_count != '0);

  // Port 2 may only retire the next entry if it targets a different
  // register; two partial writes to one register must land in order.
  assign w_wb2_v = (r_count >= CW'(2)) && (r_waddr[w_head1] != r_waddr[r_head]);

  assign w_num_drn = CW'(w_wb1_v) + CW'(w_wb2_v);

  // Regfile write ports, driven straight from stored entries and forced to
  // zero when they carry nothing.
  assign wb1_we    = w_wb1_v ? r_we[r_head]    : 4'd0;
  assign wb1_waddr = w_wb1_v ? r_waddr[r_head] : '0;
  assign wb1_wdata = w_wb1_v ? r_wdata[r_head] : 32'd0;
  assign wb2_we    = w_wb2_v ? r_we[w_head1]    : 4'd0;
  assign wb2_waddr = w_wb2_v ? r_waddr[w_head1] : '0;
  assign wb2_wdata = w_wb2_v ? r_wdata[w_head1] : 32'd0;

  assign count = r_count;

  // A slot holds a live entry when its distance from head is below count.
  for (genvar j = 0; j < DEPTH; j++) begin : g_slot
    logic [PW-1:0] w_off;
    assign w_off           = PW'(j) - r_head;
    assign w_slot_valid[j] = ({1'b0, w_off} < r_count);
  end

  // Hazard lookup: any live entry, including one retiring this cycle, that
  // writes the queried register marks it busy. The zero register is never busy.
  always_comb begin
    w_busy = 4'd0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_slot_valid[k] && (chk_addr[i*AW +: AW] != '0) &&
            (r_waddr[k] == chk_addr[i*AW +: AW])) begin
          w_busy[i] = 1'b1;
        end
      end
    end
  end

  assign chk_busy = w_busy;

  // Pointer and count update: enqueue and drain may happen in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_num_drn);
      r_tail  <= r_tail + PW'(w_num_acc);
      r_count <= r_count + w_num_acc - w_num_drn;
    end
  end

  // Entry writes: enq0 at tail, enq1 in the following free slot.
  always_ff @(posedge clk) begin
    if (w_acc0) begin
      r_waddr[r_tail] <= enq0_waddr;
      r_we[r_tail]    <= enq0_we;
      r_wdata[r_tail] <= enq0_wdata;
    end
    if (w_acc1) begin
      r_waddr[w_slot1] <= enq1_waddr;
      r_we[w_slot1]    <= enq1_we;
      r_wdata[w_slot1] <= enq1_wdata;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: reset, single and paired enqueues, discards,
// full-queue back-pressure, randomised traffic across pointer wrap, and
// reset in the middle of operation.
module tb_wb_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 6;
  localparam int EW    = AW + 4 + 32;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  logic            enq0_valid, enq1_valid;
  logic [AW-1:0]   enq0_waddr, enq1_waddr;
  logic [3:0]      enq0_we, enq1_we;
  logic [31:0]     enq0_wdata, enq1_wdata;
  logic            enq_ready;
  logic [3:0]      wb1_we, wb2_we;
  logic [AW-1:0]   wb1_waddr, wb2_waddr;
  logic [31:0]     wb1_wdata, wb2_wdata;
  logic [4*AW-1:0] chk_addr;
  logic [3:0]      chk_busy;
  logic [3:0]      count;

  wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .resetn(resetn),
    .enq0_valid(enq0_valid), .enq0_waddr(enq0_waddr), .enq0_we(enq0_we), .enq0_wdata(enq0_wdata),
    .enq1_valid(enq1_valid), .enq1_waddr(enq1_waddr), .enq1_we(enq1_we), .enq1_wdata(enq1_wdata),
    .enq_ready(enq_ready),
    .wb1_we(wb1_we), .wb1_waddr(wb1_waddr), .wb1_wdata(wb1_wdata),
    .wb2_we(wb2_we), .wb2_waddr(wb2_waddr), .wb2_wdata(wb2_wdata),
    .chk_addr(chk_addr), .chk_busy(chk_busy), .count(count)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: queued entries as {waddr, we, wdata}, oldest first.
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_enq(input logic v0, input logic [AW-1:0] a0, input logic [3:0] w0,
                         input logic [31:0] d0, input logic v1, input logic [AW-1:0] a1,
                         input logic [3:0] w1, input logic [31:0] d1);
    enq0_valid = v0; enq0_waddr = a0; enq0_we = w0; enq0_wdata = d0;
    enq1_valid = v1; enq1_waddr = a1; enq1_we = w1; enq1_wdata = d1;
  endtask

  task automatic idle();
    set_enq(1'b0, '0, 4'd0, 32'd0, 1'b0, '0, 4'd0, 32'd0);
  endtask

  // Advance one edge, updating the scoreboard with what that edge retires
  // and accepts.
  task automatic tick();
    int n;
    int d;
    logic rdy;
    if (resetn) begin
      n   = exp_q.size();
      rdy = (n <= DEPTH - 2);
      d   = 0;
      if (n >= 1) d = 1;
      if (n >= 2 && exp_q[1][EW-1 -: AW] != exp_q[0][EW-1 -: AW]) d = 2;
      repeat (d) void'(exp_q.pop_front());
      if (enq0_valid && rdy && enq0_we != 4'd0 && enq0_waddr != '0)
        exp_q.push_back({enq0_waddr, enq0_we, enq0_wdata});
      if (enq1_valid && rdy && enq1_we != 4'd0 && enq1_waddr != '0)
        exp_q.push_back({enq1_waddr, enq1_we, enq1_wdata});
    end else begin
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic v2;
    v2 = (exp_q.size() >= 2) && (exp_q[1][EW-1 -: AW] != exp_q[0][EW-1 -: AW]);
    chk({tag, ".count"}, count, exp_q.size());
    chk({tag, ".ready"}, enq_ready, (exp_q.size() <= DEPTH - 2));
    if (exp_q.size() >= 1)
      chk({tag, ".wb1"}, {wb1_waddr, wb1_we, wb1_wdata}, exp_q[0]);
    else
      chk({tag, ".wb1_we"}, wb1_we, 4'd0);
    if (v2)
      chk({tag, ".wb2"}, {wb2_waddr, wb2_we, wb2_wdata}, exp_q[1]);
    else
      chk({tag, ".wb2_off"}, {wb2_waddr, wb2_we, wb2_wdata}, 0);
  endtask

  task automatic check_busy(input string tag);
    logic [3:0]    e;
    logic [AW-1:0] a;
    e = 4'd0;
    for (int i = 0; i < 4; i++) begin
      a = chk_addr[i*AW +: AW];
      if (a != '0) begin
        foreach (exp_q[k]) if (exp_q[k][EW-1 -: AW] == a) e[i] = 1'b1;
      end
    end
    chk(tag, chk_busy, e);
  endtask

  initial begin
    // Reset state
    resetn = 1'b0;
    idle();
    chk_addr = {6'd4, 6'd3, 6'd2, 6'd1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", count, 0);
    chk("rst.ready", enq_ready, 1);
    chk("rst.wb1", {wb1_we, wb1_waddr, wb1_wdata}, 0);
    chk("rst.wb2", {wb2_we, wb2_waddr, wb2_wdata}, 0);
    chk("rst.busy", chk_busy, 0);
    resetn = 1'b1;

    // Single enqueue, visible one cycle later, gone the cycle after
    chk_addr = {6'd0, 6'd0, 6'd0, 6'd5};
    set_enq(1'b1, 6'd5, 4'hF, 32'h11223344, 1'b0, '0, 4'd0, 32'd0);
    chk("single.nobypass_we", wb1_we, 0);
    chk("single.nobypass_busy", chk_busy, 0);
    tick();
    idle();
    chk("single.wb1", {wb1_we, wb1_waddr, wb1_wdata}, {4'hF, 6'd5, 32'h11223344});
    chk("single.count1", count, 1);
    chk("single.busy", chk_busy, 4'b0001);
    check_model("single");
    tick();
    chk("single.drained_we", wb1_we, 0);
    chk("single.count0", count, 0);
    chk("single.busy_clr", chk_busy, 0);

    // Same-address pair drains one per cycle, in order
    set_enq(1'b1, 6'd7, 4'hF, 32'hA, 1'b1, 6'd7, 4'h3, 32'hBBBB);
    tick();
    idle();
    chk("same.wb1_a", {wb1_we, wb1_waddr, wb1_wdata}, {4'hF, 6'd7, 32'hA});
    chk("same.wb2_a", {wb2_we, wb2_waddr, wb2_wdata}, 0);
    chk("same.count2", count, 2);
    tick();
    chk("same.wb1_b", {wb1_we, wb1_waddr, wb1_wdata}, {4'h3, 6'd7, 32'hBBBB});
    chk("same.wb2_b", wb2_we, 0);
    chk("same.count1", count, 1);
    tick();
    chk("same.count0", count, 0);

    // Zero address and zero byte enables are discarded
    chk_addr = {6'd0, 6'd0, 6'd9, 6'd0};
    set_enq(1'b1, 6'd0, 4'hF, 32'hDEAD, 1'b1, 6'd9, 4'h0, 32'hBEEF);
    tick();
    idle();
    chk("discard.count", count, 0);
    chk("discard.wb1_we", wb1_we, 0);
    chk("discard.busy", chk_busy, 0);

    // Distinct-address pair drains through both ports at once
    set_enq(1'b1, 6'd1, 4'hF, 32'h1111, 1'b1, 6'd2, 4'hC, 32'h2222);
    tick();
    idle();
    chk("pair.wb1", {wb1_we, wb1_waddr, wb1_wdata}, {4'hF, 6'd1, 32'h1111});
    chk("pair.wb2", {wb2_we, wb2_waddr, wb2_wdata}, {4'hC, 6'd2, 32'h2222});
    chk("pair.count2", count, 2);
    tick();
    chk("pair.count0", count, 0);
    chk("pair.wb1_off", wb1_we, 0);

    // Fill to DEPTH-1 with same-address pairs, then push against a full queue
    chk_addr = {6'd0, 6'd0, 6'd4, 6'd3};
    for (int i = 0; i < 6; i++) begin
      set_enq(1'b1, 6'd3, 4'hF, 32'(i), 1'b1, 6'd3, 4'h1, 32'(i + 100));
      tick();
      check_model("fill");
    end
    idle();
    chk("full.count7", count, 7);
    chk("full.ready0", enq_ready, 0);
    set_enq(1'b1, 6'd4, 4'hF, 32'h4444, 1'b1, 6'd4, 4'hF, 32'h5555);
    tick();
    idle();
    chk("full.count6", count, 6);
    chk("full.dropped_busy", chk_busy[1], 0);
    check_model("full");
    for (int i = 0; i < 16 && exp_q.size() != 0; i++) begin
      tick();
      check_model("filldrain");
      check_busy("filldrain.busy");
    end
    chk("filldrain.empty", count, 0);

    // Randomised dual-enqueue traffic across pointer wrap
    chk_addr = {6'd4, 6'd3, 6'd2, 6'd1};
    for (int i = 0; i < 20; i++) begin
      set_enq($urandom_range(0, 3) != 0, 6'($urandom_range(0, 4)), 4'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 3) != 0, 6'($urandom_range(0, 4)), 4'($urandom_range(0, 15)), $urandom);
      check_busy("rand.busy_pre");
      tick();
      check_model("rand");
      check_busy("rand.busy");
    end
    idle();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      tick();
      check_model("randdrain");
      check_busy("randdrain.busy");
    end
    chk("randdrain.empty", count, 0);

    // Reset in the middle of operation
    chk_addr = {6'd0, 6'd0, 6'd0, 6'd6};
    for (int i = 0; i < 4; i++) begin
      set_enq(1'b1, 6'd6, 4'hF, 32'(i), 1'b1, 6'd6, 4'hF, 32'(i + 16));
      tick();
    end
    idle();
    chk("midrst.count5", count, 5);
    #1;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst.count", count, 0);
    chk("midrst.wb1_we", wb1_we, 0);
    chk("midrst.wb2_we", wb2_we, 0);
    chk("midrst.ready", enq_ready, 1);
    chk("midrst.busy", chk_busy, 0);
    set_enq(1'b1, 6'd6, 4'hF, 32'h99, 1'b0, '0, 4'd0, 32'd0);
    tick();
    chk("midrst.held_count", count, 0);
    chk("midrst.held_we", wb1_we, 0);
    resetn = 1'b1;
    idle();
    tick();
    chk("postrst.count", count, 0);
    chk("postrst.wb1_we", wb1_we, 0);
    tick();
    chk("postrst.wb1_we2", wb1_we, 0);

    // Normal operation right after release
    set_enq(1'b1, 6'd2, 4'hF, 32'h55, 1'b0, '0, 4'd0, 32'd0);
    tick();
    idle();
    chk("postrst.wb1", {wb1_we, wb1_waddr, wb1_wdata}, {4'hF, 6'd2, 32'h55});
    chk("postrst.count1", count, 1);
    tick();
    chk("postrst.count0", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of queue entries; power of two, minimum 4.
REQ-002 Parameter AW, default 6, register address width, matching the regfile address type.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 resetn  in  1  reset, asynchronous and active-low; clears all state immediately.
REQ-005 enq0_valid  in  1  write request from producer 0; older of the two in the same cycle.
REQ-006 enq0_waddr/enq0_we/enq0_wdata  in  AW/4/32  destination, byte enables, data.
REQ-007 enq1_valid  in  1  write request from producer 1; younger than enq0.
REQ-008 enq1_waddr/enq1_we/enq1_wdata  in  AW/4/32  destination, byte enables, data.
REQ-009 enq_ready  out  1  queue can take two requests this cycle.
REQ-010 wb1_we/wb1_waddr/wb1_wdata  out  4/AW/32  regfile write port 1, oldest entry.
REQ-011 wb2_we/wb2_waddr/wb2_wdata  out  4/AW/32  regfile write port 2, second-oldest entry.
REQ-012 chk_addr  in  4*AW  four packed issue-stage source addresses to test.
REQ-013 chk_busy  out  4  bit i set when chk_addr[i] has a queued pending write.
REQ-014 count  out  $clog2(DEPTH)+1  current number of valid entries.

Function
REQ-015 The block SHALL be a circular FIFO with registered head pointer, tail pointer and count.
REQ-016 A request SHALL be accepted only if valid, enq_ready=1, we!=0 and waddr!=0; other requests are discarded and are not stored.
REQ-017 enq_ready SHALL be 1 exactly when count <= DEPTH-2, from registered count only.
REQ-018 Accepted requests SHALL be written at tail in order enq0 then enq1.
REQ-019 A lone accepted enq1 SHALL take slot tail.
REQ-020 Tail SHALL advance by the number accepted, 0 to 2, modulo DEPTH.
REQ-021 wb outputs SHALL be combinational from registered entries.
REQ-022 A request accepted at edge N SHALL appear on a wb port during cycle N+1 at the earliest; there is no enqueue-to-port bypass.
REQ-023 When count>=1, wb1 SHALL present entry head; otherwise wb1_we=0.
REQ-024 wb2 SHALL present entry head+1 only when count>=2 and its waddr differs from head's waddr.
REQ-025 When the addresses are equal, wb2_we SHALL be 0 so partial byte writes merge in order.
REQ-026 When wb2_we=0, wb2_waddr and wb2_wdata SHALL be 0.
REQ-027 The regfile always accepts. Head SHALL advance each cycle by the number of wb ports with we!=0, modulo DEPTH.
REQ-028 count_next SHALL be count + accepted - drained, with enqueue and drain in the same cycle permitted.
REQ-029 Under REQ-017 the sum never exceeds DEPTH; the queue holds full state without overrun.
REQ-030 chk_busy[i] SHALL be 1 when any valid entry, including entries draining this cycle, has waddr == chk_addr[i].
REQ-031 chk_busy[i] SHALL be 0 when chk_addr[i]==0.
REQ-032 chk_busy SHALL NOT reflect requests arriving in the current cycle.
REQ-033 Pointer wrap SHALL be seamless; an entry at DEPTH-1 followed by an entry at 0 drains as a pair.

Reset
REQ-034 While resetn=0: head=0, tail=0, count=0, enq_ready=1, wb1_we=0, wb2_we=0, all wb addr/data=0, chk_busy=0.
REQ-035 Entry storage need not be reset; valid tracking is via count only.
REQ-036 Reset mid-operation SHALL discard all queued entries with no wb write in the reset cycle.
REQ-037 After release, the first edge with resetn=1 SHALL behave as normal operation.

Verification
REQ-038 Enq0 {waddr=5, we=F, data=0x11223344} at edge 1 -> cycle 2: wb1 presents {F,5,0x11223344}, count=1; cycle 3: wb1_we=0, count=0.
REQ-039 Same cycle enq0 {7,F,0xA} and enq1 {7,3,0xBBBB} -> drains over two cycles: wb1 {7,F,0xA}, then wb1 {7,3,0xBBBB}; wb2_we=0 in both.
REQ-040 Enq0 {waddr=0} and enq1 {we=0} -> nothing stored, count stays 0, chk_busy=0 for chk_addr=0.
REQ-041 Prefill to count=7 with DEPTH=8 -> enq_ready=0; requests that cycle are dropped and count decreases by the drain amount only.
REQ-042 Run 20 random dual-enqueue cycles across pointer wrap -> wb order matches enqueue order, and chk_busy for each queued address stays 1 until its last entry drains.
REQ-043 Assert resetn=0 with count=5 -> count=0, wb*_we=0 and enq_ready=1 immediately, and no writes after release.
